// File: rtl/l15_req_arbiter.sv
// Arbitrates the single L1.5 request channel between the icache miss path and
// the dcache path, tracks outstanding transactions and routes L1.5 returns.
module l15_req_arbiter #(
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64,
  parameter int BE_W    = 8,
  parameter int TID_W   = 3,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              ic_req_val_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  input  logic              ic_req_nc_i,
  input  logic [TID_W-1:0]  ic_req_tid_i,
  output logic              ic_req_ack_o,

  input  logic              dc_req_val_i,
  input  logic [4:0]        dc_req_type_i,
  input  logic [2:0]        dc_req_size_i,
  input  logic              dc_req_nc_i,
  input  logic [TID_W-1:0]  dc_req_tid_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [DATA_W-1:0] dc_req_data_i,
  input  logic [3:0]        dc_req_amo_i,
  input  logic [BE_W-1:0]   dc_req_be_i,
  output logic              dc_req_ack_o,

  output logic              l15_val_o,
  output logic [4:0]        l15_rqtype_o,
  output logic              l15_nc_o,
  output logic [2:0]        l15_size_o,
  output logic [TID_W-1:0]  l15_threadid_o,
  output logic [ADDR_W-1:0] l15_address_o,
  output logic [DATA_W-1:0] l15_data_o,
  output logic [3:0]        l15_amo_op_o,
  output logic [BE_W-1:0]   l15_be_o,
  input  logic              l15_ack_i,

  input  logic              l15_rtrn_val_i,
  input  logic [3:0]        l15_rtrn_type_i,
  output logic              l15_req_ack_o,
  output logic              ic_rtrn_val_o,
  output logic              dc_rtrn_val_o,

  output logic [CNT_W-1:0]  ic_outstanding_o,
  output logic [CNT_W-1:0]  dc_outstanding_o,
  output logic              proto_err_o
);

  localparam logic [4:0]       IMISS_RQ   = 5'b10000;
  localparam logic [2:0]       ILINE_SIZE = 3'b111;
  localparam logic [3:0]       AMO_NONE   = 4'b0000;
  localparam logic [3:0]       RT_LOAD    = 4'b0000;
  localparam logic [3:0]       RT_IFILL   = 4'b0001;
  localparam logic [3:0]       RT_EVICT   = 4'b0011;
  localparam logic [3:0]       RT_ST_ACK  = 4'b0100;
  localparam logic [3:0]       RT_INT     = 4'b0111;
  localparam logic [3:0]       RT_ATOMIC  = 4'b1110;
  localparam logic [CNT_W:0]   MAX_CNT    = (CNT_W + 1)'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_WAIT_ACK
  } state_t;

  state_t            r_state;
  logic              r_last_ic;
  logic              r_src_ic;
  logic [CNT_W-1:0]  r_ic_cnt;
  logic [CNT_W-1:0]  r_dc_cnt;
  logic              r_perr;

  logic              r_val;
  logic [4:0]        r_rqtype;
  logic              r_nc;
  logic [2:0]        r_size;
  logic [TID_W-1:0]  r_tid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_amo;
  logic [BE_W-1:0]   r_be;

  logic              w_ack_cycle;
  logic              w_ic_inc;
  logic              w_dc_inc;
  logic [CNT_W:0]    w_ic_eff;
  logic [CNT_W:0]    w_dc_eff;
  logic              w_ic_elig;
  logic              w_dc_elig;
  logic              w_can_grant;
  logic              w_grant_ic;
  logic              w_grant_dc;
  logic              w_grant;

  logic              w_rt_ifill;
  logic              w_rt_dc;
  logic              w_rt_bcast;
  logic              w_rt_bad;
  logic              w_ic_underflow;
  logic              w_dc_underflow;

  // An acked request counts toward its source before the next grant is chosen.
  assign w_ack_cycle = (r_state == S_WAIT_ACK) && l15_ack_i;
  assign w_ic_inc    = w_ack_cycle && r_src_ic;
  assign w_dc_inc    = w_ack_cycle && !r_src_ic;
  assign w_ic_eff    = {1'b0, r_ic_cnt} + {{CNT_W{1'b0}}, w_ic_inc};
  assign w_dc_eff    = {1'b0, r_dc_cnt} + {{CNT_W{1'b0}}, w_dc_inc};
  assign w_ic_elig   = ic_req_val_i && (w_ic_eff < MAX_CNT);
  assign w_dc_elig   = dc_req_val_i && (w_dc_eff < MAX_CNT);

  assign w_can_grant = (r_state == S_IDLE) || w_ack_cycle;
  assign w_grant_ic  = w_can_grant && w_ic_elig && (!w_dc_elig || !r_last_ic);
  assign w_grant_dc  = w_can_grant && w_dc_elig && (!w_ic_elig || r_last_ic);
  assign w_grant     = w_grant_ic || w_grant_dc;

  assign ic_req_ack_o = w_grant_ic;
  assign dc_req_ack_o = w_grant_dc;

  assign w_rt_ifill = l15_rtrn_val_i && (l15_rtrn_type_i == RT_IFILL);
  assign w_rt_dc    = l15_rtrn_val_i && ((l15_rtrn_type_i == RT_LOAD)   ||
                                         (l15_rtrn_type_i == RT_ST_ACK) ||
                                         (l15_rtrn_type_i == RT_ATOMIC));
  assign w_rt_bcast = l15_rtrn_val_i && ((l15_rtrn_type_i == RT_EVICT) ||
                                         (l15_rtrn_type_i == RT_INT));
  assign w_rt_bad   = l15_rtrn_val_i && !w_rt_ifill && !w_rt_dc && !w_rt_bcast;

  assign l15_req_ack_o = l15_rtrn_val_i;
  assign ic_rtrn_val_o = w_rt_ifill || w_rt_bcast;
  assign dc_rtrn_val_o = w_rt_dc || w_rt_bcast;

  assign w_ic_underflow = w_rt_ifill && !w_ic_inc && (r_ic_cnt == '0);
  assign w_dc_underflow = w_rt_dc && !w_dc_inc && (r_dc_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_last_ic <= 1'b0;
      r_src_ic  <= 1'b0;
      r_val     <= 1'b0;
      r_rqtype  <= '0;
      r_nc      <= 1'b0;
      r_size    <= '0;
      r_tid     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_amo     <= '0;
      r_be      <= '0;
    end else begin
      if (w_grant) begin
        r_state   <= S_WAIT_ACK;
        r_last_ic <= w_grant_ic;
        r_src_ic  <= w_grant_ic;
        r_val     <= 1'b1;
        if (w_grant_ic) begin
          r_rqtype <= IMISS_RQ;
          r_nc     <= ic_req_nc_i;
          r_size   <= ILINE_SIZE;
          r_tid    <= ic_req_tid_i;
          r_addr   <= ic_req_addr_i;
          r_data   <= '0;
          r_amo    <= AMO_NONE;
          r_be     <= '1;
        end else begin
          r_rqtype <= dc_req_type_i;
          r_nc     <= dc_req_nc_i;
          r_size   <= dc_req_size_i;
          r_tid    <= dc_req_tid_i;
          r_addr   <= dc_req_addr_i;
          r_data   <= dc_req_data_i;
          r_amo    <= dc_req_amo_i;
          r_be     <= dc_req_be_i;
        end
      end else if (w_ack_cycle) begin
        r_state <= S_IDLE;
        r_val   <= 1'b0;
      end
    end
  end

  // Simultaneous increment and decrement cancel; an unmatched decrement at zero is an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ic_cnt <= '0;
      r_dc_cnt <= '0;
      r_perr   <= 1'b0;
    end else begin
      if (w_ic_inc && !w_rt_ifill) begin
        r_ic_cnt <= r_ic_cnt + CNT_ONE;
      end else if (w_rt_ifill && !w_ic_inc && !w_ic_underflow) begin
        r_ic_cnt <= r_ic_cnt - CNT_ONE;
      end
      if (w_dc_inc && !w_rt_dc) begin
        r_dc_cnt <= r_dc_cnt + CNT_ONE;
      end else if (w_rt_dc && !w_dc_inc && !w_dc_underflow) begin
        r_dc_cnt <= r_dc_cnt - CNT_ONE;
      end
      if (w_rt_bad || w_ic_underflow || w_dc_underflow) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign l15_val_o        = r_val;
  assign l15_rqtype_o     = r_rqtype;
  assign l15_nc_o         = r_nc;
  assign l15_size_o       = r_size;
  assign l15_threadid_o   = r_tid;
  assign l15_address_o    = r_addr;
  assign l15_data_o       = r_data;
  assign l15_amo_op_o     = r_amo;
  assign l15_be_o         = r_be;
  assign ic_outstanding_o = r_ic_cnt;
  assign dc_outstanding_o = r_dc_cnt;
  assign proto_err_o      = r_perr;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed self-checking bench for l15_req_arbiter: arbitration, formatting,
// outstanding limits, return routing, protocol errors and async reset.
module tb_l15_req_arbiter;

  localparam int ADDR_W  = 40;
  localparam int DATA_W  = 64;
  localparam int BE_W    = 8;
  localparam int TID_W   = 3;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              ic_req_val_i;
  logic [ADDR_W-1:0] ic_req_addr_i;
  logic              ic_req_nc_i;
  logic [TID_W-1:0]  ic_req_tid_i;
  logic              ic_req_ack_o;
  logic              dc_req_val_i;
  logic [4:0]        dc_req_type_i;
  logic [2:0]        dc_req_size_i;
  logic              dc_req_nc_i;
  logic [TID_W-1:0]  dc_req_tid_i;
  logic [ADDR_W-1:0] dc_req_addr_i;
  logic [DATA_W-1:0] dc_req_data_i;
  logic [3:0]        dc_req_amo_i;
  logic [BE_W-1:0]   dc_req_be_i;
  logic              dc_req_ack_o;
  logic              l15_val_o;
  logic [4:0]        l15_rqtype_o;
  logic              l15_nc_o;
  logic [2:0]        l15_size_o;
  logic [TID_W-1:0]  l15_threadid_o;
  logic [ADDR_W-1:0] l15_address_o;
  logic [DATA_W-1:0] l15_data_o;
  logic [3:0]        l15_amo_op_o;
  logic [BE_W-1:0]   l15_be_o;
  logic              l15_ack_i;
  logic              l15_rtrn_val_i;
  logic [3:0]        l15_rtrn_type_i;
  logic              l15_req_ack_o;
  logic              ic_rtrn_val_o;
  logic              dc_rtrn_val_o;
  logic [CNT_W-1:0]  ic_outstanding_o;
  logic [CNT_W-1:0]  dc_outstanding_o;
  logic              proto_err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  l15_req_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .TID_W(TID_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ic_req_val_i(ic_req_val_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_nc_i(ic_req_nc_i),
    .ic_req_tid_i(ic_req_tid_i), .ic_req_ack_o(ic_req_ack_o),
    .dc_req_val_i(dc_req_val_i), .dc_req_type_i(dc_req_type_i), .dc_req_size_i(dc_req_size_i),
    .dc_req_nc_i(dc_req_nc_i), .dc_req_tid_i(dc_req_tid_i), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_data_i(dc_req_data_i), .dc_req_amo_i(dc_req_amo_i), .dc_req_be_i(dc_req_be_i),
    .dc_req_ack_o(dc_req_ack_o),
    .l15_val_o(l15_val_o), .l15_rqtype_o(l15_rqtype_o), .l15_nc_o(l15_nc_o),
    .l15_size_o(l15_size_o), .l15_threadid_o(l15_threadid_o), .l15_address_o(l15_address_o),
    .l15_data_o(l15_data_o), .l15_amo_op_o(l15_amo_op_o), .l15_be_o(l15_be_o),
    .l15_ack_i(l15_ack_i),
    .l15_rtrn_val_i(l15_rtrn_val_i), .l15_rtrn_type_i(l15_rtrn_type_i),
    .l15_req_ack_o(l15_req_ack_o), .ic_rtrn_val_o(ic_rtrn_val_o), .dc_rtrn_val_o(dc_rtrn_val_o),
    .ic_outstanding_o(ic_outstanding_o), .dc_outstanding_o(dc_outstanding_o),
    .proto_err_o(proto_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 3 time units after each rising edge.
  task automatic nextCycle();
    @(posedge clk_i);
    #3;
  endtask

  initial begin
    rst_ni = 1'b0;
    ic_req_val_i = 1'b0; ic_req_addr_i = '0; ic_req_nc_i = 1'b0; ic_req_tid_i = '0;
    dc_req_val_i = 1'b0; dc_req_type_i = '0; dc_req_size_i = '0; dc_req_nc_i = 1'b0;
    dc_req_tid_i = '0; dc_req_addr_i = '0; dc_req_data_i = '0; dc_req_amo_i = '0;
    dc_req_be_i = '0; l15_ack_i = 1'b0; l15_rtrn_val_i = 1'b0; l15_rtrn_type_i = '0;

    repeat (2) @(posedge clk_i);
    #3;
    check("rst_val", l15_val_o, 0);
    check("rst_rqtype", l15_rqtype_o, 0);
    check("rst_ic_ack", ic_req_ack_o, 0);
    check("rst_dc_ack", dc_req_ack_o, 0);
    check("rst_ic_cnt", ic_outstanding_o, 0);
    check("rst_dc_cnt", dc_outstanding_o, 0);
    check("rst_perr", proto_err_o, 0);
    rst_ni = 1'b1;
    nextCycle();

    // Both requesting with the L1.5 acking every cycle: IC, DC, IC, DC back to back.
    ic_req_val_i = 1'b1; ic_req_addr_i = 40'h00_0000_0100; ic_req_tid_i = 3'd1;
    dc_req_val_i = 1'b1; dc_req_type_i = 5'b00001; dc_req_addr_i = 40'h00_0000_0200;
    l15_ack_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("alt_ic_ack%0d", i), ic_req_ack_o, (i % 2 == 0) ? 1 : 0);
      check($sformatf("alt_dc_ack%0d", i), dc_req_ack_o, (i % 2 == 1) ? 1 : 0);
      nextCycle();
      check($sformatf("alt_val%0d", i), l15_val_o, 1);
      check($sformatf("alt_rqtype%0d", i), l15_rqtype_o, (i % 2 == 0) ? 5'b10000 : 5'b00001);
    end
    ic_req_val_i = 1'b0; dc_req_val_i = 1'b0;
    #1;
    check("alt_end_ic_ack", ic_req_ack_o, 0);
    check("alt_end_dc_ack", dc_req_ack_o, 0);
    nextCycle();
    l15_ack_i = 1'b0;
    check("alt_end_val", l15_val_o, 0);
    check("alt_ic_cnt", ic_outstanding_o, 2);
    check("alt_dc_cnt", dc_outstanding_o, 2);

    // IC alone: formatting and hold until ack.
    ic_req_val_i = 1'b1; ic_req_addr_i = 40'h80_0000_1040; ic_req_tid_i = 3'd3; ic_req_nc_i = 1'b0;
    #1;
    check("ic_ack_pulse", ic_req_ack_o, 1);
    check("ic_no_dc_ack", dc_req_ack_o, 0);
    nextCycle();
    ic_req_val_i = 1'b0;
    #1;
    check("ic_val", l15_val_o, 1);
    check("ic_rqtype", l15_rqtype_o, 5'b10000);
    check("ic_size", l15_size_o, 3'b111);
    check("ic_be", l15_be_o, 8'hFF);
    check("ic_data", l15_data_o, 0);
    check("ic_amo", l15_amo_op_o, 0);
    check("ic_addr", l15_address_o, 40'h80_0000_1040);
    check("ic_tid", l15_threadid_o, 3);
    check("ic_ack_once", ic_req_ack_o, 0);
    nextCycle();
    check("ic_hold_val", l15_val_o, 1);
    check("ic_hold_addr", l15_address_o, 40'h80_0000_1040);
    l15_ack_i = 1'b1;
    #1;
    check("ic_ackcyc_no_grant", ic_req_ack_o, 0);
    nextCycle();
    l15_ack_i = 1'b0;
    check("ic_done_val", l15_val_o, 0);
    check("ic_cnt_after", ic_outstanding_o, 3);

    // DC pass-through, then ack together with ST_ACK return: count unchanged.
    dc_req_val_i = 1'b1; dc_req_type_i = 5'b00000; dc_req_size_i = 3'b011; dc_req_nc_i = 1'b1;
    dc_req_tid_i = 3'd5; dc_req_addr_i = 40'h12_3456_7890; dc_req_data_i = 64'h1122_3344_5566_7788;
    dc_req_amo_i = 4'h3; dc_req_be_i = 8'h0F;
    #1;
    check("dc_ack_pulse", dc_req_ack_o, 1);
    nextCycle();
    dc_req_val_i = 1'b0;
    #1;
    check("dc_rqtype", l15_rqtype_o, 5'b00000);
    check("dc_size", l15_size_o, 3'b011);
    check("dc_nc", l15_nc_o, 1);
    check("dc_tid", l15_threadid_o, 5);
    check("dc_addr", l15_address_o, 40'h12_3456_7890);
    check("dc_data", l15_data_o, 64'h1122_3344_5566_7788);
    check("dc_amo", l15_amo_op_o, 4'h3);
    check("dc_be", l15_be_o, 8'h0F);
    l15_ack_i = 1'b1; l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b0100;
    #1;
    check("stack_dc_rtrn", dc_rtrn_val_o, 1);
    check("stack_ic_rtrn", ic_rtrn_val_o, 0);
    check("stack_req_ack", l15_req_ack_o, 1);
    nextCycle();
    l15_ack_i = 1'b0; l15_rtrn_val_i = 1'b0;
    check("stack_dc_cnt", dc_outstanding_o, 2);
    check("stack_val", l15_val_o, 0);

    // Broadcast returns leave counts alone.
    l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b0011;
    #1;
    check("evict_ic_rtrn", ic_rtrn_val_o, 1);
    check("evict_dc_rtrn", dc_rtrn_val_o, 1);
    nextCycle();
    l15_rtrn_type_i = 4'b0111;
    #1;
    check("int_ic_rtrn", ic_rtrn_val_o, 1);
    check("int_dc_rtrn", dc_rtrn_val_o, 1);
    nextCycle();
    check("bcast_ic_cnt", ic_outstanding_o, 3);
    check("bcast_dc_cnt", dc_outstanding_o, 2);

    // Drain: three IFILL_RET, then LOAD_RET and ATOMIC_RES.
    l15_rtrn_type_i = 4'b0001;
    repeat (3) nextCycle();
    l15_rtrn_type_i = 4'b0000;
    nextCycle();
    l15_rtrn_type_i = 4'b1110;
    #1;
    check("amo_dc_rtrn", dc_rtrn_val_o, 1);
    nextCycle();
    l15_rtrn_val_i = 1'b0;
    check("drain_ic_cnt", ic_outstanding_o, 0);
    check("drain_dc_cnt", dc_outstanding_o, 0);
    check("drain_perr", proto_err_o, 0);

    // IFILL_RET with nothing outstanding.
    l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b0001;
    #1;
    check("uflow_ic_rtrn", ic_rtrn_val_o, 1);
    nextCycle();
    l15_rtrn_val_i = 1'b0;
    check("uflow_ic_cnt", ic_outstanding_o, 0);
    check("uflow_perr", proto_err_o, 1);
    repeat (2) nextCycle();
    check("perr_sticky", proto_err_o, 1);

    // DC limit: four issue, the fifth waits for a return.
    dc_req_val_i = 1'b1; dc_req_type_i = 5'b00000; l15_ack_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lim_ack%0d", i), dc_req_ack_o, 1);
      nextCycle();
    end
    check("lim_ack4", dc_req_ack_o, 0);
    nextCycle();
    l15_ack_i = 1'b0;
    #1;
    check("lim_blocked", dc_req_ack_o, 0);
    check("lim_cnt4", dc_outstanding_o, 4);
    check("lim_val", l15_val_o, 0);
    l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b0000;
    #1;
    check("lim_rtrn", dc_rtrn_val_o, 1);
    check("lim_still_blocked", dc_req_ack_o, 0);
    nextCycle();
    l15_rtrn_val_i = 1'b0;
    #1;
    check("lim_cnt3", dc_outstanding_o, 3);
    check("lim_fifth_ack", dc_req_ack_o, 1);
    nextCycle();
    dc_req_val_i = 1'b0;
    check("lim_fifth_val", l15_val_o, 1);

    // Reset in WAIT_ACK drops the request immediately.
    rst_ni = 1'b0;
    #1;
    check("arst_val", l15_val_o, 0);
    check("arst_ic_cnt", ic_outstanding_o, 0);
    check("arst_dc_cnt", dc_outstanding_o, 0);
    check("arst_perr", proto_err_o, 0);
    nextCycle();
    rst_ni = 1'b1;
    ic_req_val_i = 1'b1; dc_req_val_i = 1'b1;
    #1;
    check("arst_tie_ic", ic_req_ack_o, 1);
    check("arst_tie_dc", dc_req_ack_o, 0);
    nextCycle();
    ic_req_val_i = 1'b0; dc_req_val_i = 1'b0;
    check("arst_rqtype", l15_rqtype_o, 5'b10000);
    l15_ack_i = 1'b1;
    nextCycle();
    l15_ack_i = 1'b0;
    check("arst_done_val", l15_val_o, 0);

    // Unknown return type: no routing, error flagged.
    l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = 4'b1111;
    #1;
    check("bad_ic_rtrn", ic_rtrn_val_o, 0);
    check("bad_dc_rtrn", dc_rtrn_val_o, 0);
    check("bad_req_ack", l15_req_ack_o, 1);
    nextCycle();
    l15_rtrn_val_i = 1'b0;
    check("bad_perr", proto_err_o, 1);
    check("bad_ic_cnt", ic_outstanding_o, 1);
    check("bad_dc_cnt", dc_outstanding_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Sequences the single L1.5 request channel between the instruction-cache miss path and the data-cache path (load/store/atomic).
- Formats icache fills as L15_IMISS_RQ cache-line requests and holds each request stable until the L1.5 acknowledges it.
- Tracks outstanding transactions per requester and routes each L1.5 return to the owning cache.
- Sits between the two L1 caches and the L1.5 transducer.

Parameters:
ADDR_W, 40, physical address width on the L1.5 interface
DATA_W, 64, request data width
BE_W, 8, byte-mask width
TID_W, 3, thread/transaction-ID width
MAX_OUT, 4, maximum outstanding transactions per requester (>=1)
CNT_W, $clog2(MAX_OUT+1), outstanding-counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
ic_req_val_i  in  1  icache fill request pending
ic_req_addr_i  in  ADDR_W  line address
ic_req_nc_i  in  1  non-cacheable
ic_req_tid_i  in  TID_W  transaction ID
ic_req_ack_o  out  1  one-cycle pulse: icache request captured
dc_req_val_i  in  1  dcache request pending
dc_req_type_i  in  5  l15 request type (LOAD/STORE/ATOMIC)
dc_req_size_i  in  3  transaction size code
dc_req_nc_i  in  1  non-cacheable
dc_req_tid_i  in  TID_W  transaction ID
dc_req_addr_i  in  ADDR_W  address
dc_req_data_i  in  DATA_W  store/AMO data
dc_req_amo_i  in  4  amo_t opcode
dc_req_be_i  in  BE_W  byte mask
dc_req_ack_o  out  1  one-cycle pulse: dcache request captured
l15_val_o  out  1  request valid to L1.5
l15_rqtype_o  out  5  request type
l15_nc_o  out  1  non-cacheable
l15_size_o  out  3  size
l15_threadid_o  out  TID_W  transaction ID
l15_address_o  out  ADDR_W  address
l15_data_o  out  DATA_W  data
l15_amo_op_o  out  4  AMO opcode
l15_be_o  out  BE_W  byte mask
l15_ack_i  in  1  L1.5 accepted current request
l15_rtrn_val_i  in  1  return packet valid
l15_rtrn_type_i  in  4  return type (l15_rtrntypes_t)
l15_req_ack_o  out  1  return consumed (= l15_rtrn_val_i, combinational)
ic_rtrn_val_o  out  1  return routed to icache
dc_rtrn_val_o  out  1  return routed to dcache
ic_outstanding_o  out  CNT_W  icache outstanding count
dc_outstanding_o  out  CNT_W  dcache outstanding count
proto_err_o  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all l15_* request outputs 0; both req_ack_o 0; counters 0; proto_err_o 0; last_grant = DC, so IC wins the first tie.
- Eligibility: a requester is eligible when req_val_i=1 and its count < MAX_OUT.
- Grant: if exactly one requester is eligible, grant it. If both are eligible, grant the one that is not last_grant. Update last_grant on every grant.
- States:
  - IDLE: on any grant, capture the fields into the output registers, pulse the granted req_ack_o in the same cycle, and go to WAIT_ACK. l15_val_o=1 from the next cycle.
  - WAIT_ACK: all l15_* outputs are held stable. On l15_ack_i, increment the granted source's counter.
    - If a new grant is possible in that same cycle (eligibility re-evaluated with the incremented count), capture it and stay in WAIT_ACK. This gives back-to-back issue at 1 request/cycle.
    - Otherwise clear l15_val_o and go to IDLE.
- Requesters hold their inputs stable until they see req_ack_o. The arbiter never captures a requester while its previous request is still in the output register.
- IC formatting: rqtype=5'b10000, size=3'b111, be=all ones, data=0, amo=AMO_NONE. nc, tid and addr pass through.
- DC formatting: all fields pass through.
- Return routing:
  - IFILL_RET (0001): ic_rtrn_val_o=1; decrement IC count.
  - LOAD_RET (0000), ST_ACK (0100), ATOMIC_RES (1110): dc_rtrn_val_o=1; decrement DC count.
  - EVICT_REQ (0011) and INT_RET (0111): broadcast to both; no count change.
  - Other types: no routing; set proto_err_o.
  - Routing outputs are combinational in the same cycle as l15_rtrn_val_i.
- Counters:
  - Increment and decrement of the same counter in the same cycle leaves it unchanged.
  - A decrement at 0 is suppressed and sets proto_err_o.
  - An increment can never exceed MAX_OUT, because of the eligibility rule.
  - proto_err_o clears only on reset.
- Reset mid-transaction: l15_val_o drops immediately and all counters clear. Transactions in flight are abandoned.

Test Plan:
- IC alone: ic_req_val_i=1, addr=0x80_0000_1040 -> ic_req_ack_o pulses in cycle 0; cycle 1 l15_val_o=1, rqtype=10000, size=111, be=FF. Outputs held until l15_ack_i; ic_outstanding_o=1 after the ack.
- Both requesting continuously, l15_ack_i tied 1 -> grants alternate IC,DC,IC,DC starting with IC. l15_val_o stays high with no bubble.
- DC with MAX_OUT=4 and no returns -> 4 requests issue, 5th not acked. One LOAD_RET -> dc_rtrn_val_o=1, count 4->3, 5th request captured the next cycle.
- Same cycle: DC ack plus ST_ACK return at dc_outstanding_o=2 -> count stays 2; dc_rtrn_val_o=1.
- Return routing: EVICT_REQ -> ic_rtrn_val_o=dc_rtrn_val_o=1, counts unchanged. IFILL_RET with IC count 0 -> count stays 0, proto_err_o=1 and sticky. Type 1111 -> no routing, proto_err_o=1.
- rst_ni asserted in WAIT_ACK with counts 2/3 -> l15_val_o=0 asynchronously. After release: counts 0, first tie granted to IC.
